// File: rtl/console_mux_pkg.sv
// Shared defaults and sizing helpers for the multi-lane console FIFO.
package console_mux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Sized for the default depth; the modules size their own pointers from parameters.
    typedef logic [$clog2(DEF_DEPTH):0]     ptr_t;
    typedef logic [$clog2(DEF_DEPTH+1)-1:0] level_t;

    // Select width that stays legal for a single-lane build.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// One FWFT byte lane: storage, wrap-bit pointers, occupancy flags and sticky overflow.
module fifo_lane
    import console_mux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 12,
    parameter int PW        = $clog2(DEPTH),
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CW-1:0]    level,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      w_ptr;
    logic [PW:0]      r_ptr;
    logic [PW:0]      ptr_diff;
    logic             do_push;
    logic             do_pop;

    assign empty       = (w_ptr == r_ptr);
    assign full        = (w_ptr[PW-1:0] == r_ptr[PW-1:0]) && (w_ptr[PW] != r_ptr[PW]);
    assign ptr_diff    = w_ptr - r_ptr;
    assign level       = CW'(ptr_diff);
    assign almost_full = (level >= CW'(AF_THRESH));
    assign head        = empty ? '0 : mem[r_ptr[PW-1:0]];

    // Both qualifiers use pre-edge flags, so a same-cycle pop never frees room for a push.
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) w_ptr <= w_ptr + 1'b1;
            if (do_pop)  r_ptr <= r_ptr + 1'b1;
            if (wr_en && full) overflow <= 1'b1;
            else if (ovf_clr)  overflow <= 1'b0;
        end
    end

    // NOTE: storage has no reset; stale contents are unreachable once the pointers are zeroed.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[w_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/multi_fifo.sv
// NCH independent byte FIFOs sharing one FWFT read port selected by rd_ch.
module multi_fifo
    import console_mux_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int AF_THRESH = 12,
    parameter int CW        = $clog2(DEPTH + 1),
    parameter int SW        = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       wr_en,
    input  logic [NCH*WIDTH-1:0] wr_data,
    input  logic [SW-1:0]        rd_ch,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic [NCH-1:0]       empty,
    output logic [NCH-1:0]       full,
    output logic [NCH-1:0]       almost_full,
    output logic [NCH*CW-1:0]    level,
    output logic [NCH-1:0]       overflow,
    input  logic [NCH-1:0]       ovf_clr
);

    logic [WIDTH-1:0] head [NCH];
    logic [NCH-1:0]   lane_rd;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        // An out-of-range rd_ch matches no lane, so its pop is dropped.
        assign lane_rd[g] = rd_en && (rd_ch == SW'(g));

        fifo_lane #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en       (wr_en[g]),
            .wr_data     (wr_data[g*WIDTH +: WIDTH]),
            .rd_en       (lane_rd[g]),
            .ovf_clr     (ovf_clr[g]),
            .head        (head[g]),
            .empty       (empty[g]),
            .full        (full[g]),
            .almost_full (almost_full[g]),
            .level       (level[g*CW +: CW]),
            .overflow    (overflow[g])
        );
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == SW'(i)) begin
                rd_data  = head[i];
                rd_valid = !empty[i];
            end
        end
    end

endmodule
